wordcopy: RTL and testbench

- Memory-mapped word-copy DMA engine.
- A CPU programs destination, source and word count through an Avalon-MM slave port, then writes offset 0 to start.
- The block copies N 32-bit words from source to destination through an Avalon-MM master port into SDRAM.
- It sits between the CPU interconnect (slave side) and the SDRAM interconnect (master side).

---
 rtl/wordcopy.sv | 77 +++++++
 tb/tb_wordcopy.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wordcopy.sv
// wordcopy: memory-mapped DMA engine copying count 32-bit words from src to dst
//   clk, rst_n (sync, active-high)     : clock and reset
//   slave_*  (Avalon-MM slave)         : 0=start/status, 1=dst, 2=src, 3=count
//   master_* (Avalon-MM master)        : one outstanding read, then one write per word
module wordcopy (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_REQ  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR_REQ  = 2'd3;
    logic [1:0]  state;
    logic [31:0] dst, src, count, index, data, offs, next_index;
    logic        busy;
    always_comb begin
        busy              = state != IDLE;
        offs              = index << 2;
        next_index        = index + 32'd1;
        // stalling any CPU access while busy makes a status read block until the copy ends
        slave_waitrequest = busy & (slave_read | slave_write);
        slave_readdata    = slave_address == 4'd1 ? dst :
                            slave_address == 4'd2 ? src :
                            slave_address == 4'd3 ? count : 32'd0;
        master_read       = state == RD_REQ;
        master_write      = state == WR_REQ;
        master_address    = master_read ? src + offs : master_write ? dst + offs : 32'd0;
        master_writedata  = master_write ? data : 32'd0;
    end
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            dst   <= 32'd0;
            src   <= 32'd0;
            count <= 32'd0;
            index <= 32'd0;
            data  <= 32'd0;
        end else begin
            case (state)
                IDLE: if (slave_write) begin
                    case (slave_address)
                        4'd0: begin
                            index <= 32'd0;
                            state <= count != 32'd0 ? RD_REQ : IDLE;
                        end
                        4'd1: dst   <= slave_writedata;
                        4'd2: src   <= slave_writedata;
                        4'd3: count <= slave_writedata;
                        default: ;
                    endcase
                end
                RD_REQ: if (!master_waitrequest) state <= RD_WAIT;
                RD_WAIT: if (master_readdatavalid) begin
                    data  <= master_readdata;
                    state <= WR_REQ;
                end
                default: if (!master_waitrequest) begin
                    index <= next_index;
                    state <= next_index == count ? IDLE : RD_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wordcopy.sv
// tb_wordcopy: directed bench for wordcopy with a bench-side Avalon memory responder
module tb_wordcopy;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = 4'd0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = 32'd0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = 32'd0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    always #5 clk = ~clk;

    wordcopy dut (
        .clk(clk), .rst_n(rst_n),
        .slave_waitrequest(slave_waitrequest), .slave_address(slave_address),
        .slave_read(slave_read), .slave_readdata(slave_readdata),
        .slave_write(slave_write), .slave_writedata(slave_writedata),
        .master_waitrequest(master_waitrequest), .master_address(master_address),
        .master_read(master_read), .master_readdata(master_readdata),
        .master_readdatavalid(master_readdatavalid), .master_write(master_write),
        .master_writedata(master_writedata)
    );

    int vec = 0;
    int bad = 0;
    logic [31:0] rdata [64];
    logic [31:0] rd_addr [64];
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    int nrd = 0;
    int nwr = 0;
    int hold_err = 0;
    bit stall = 1'b0;
    int st = 0;
    bit pend = 1'b0;
    bit held = 1'b0;
    logic        h_rd, h_wr;
    logic [31:0] h_addr, h_data;

    // Memory responder: decides waitrequest mid-cycle, logs accepted requests,
    // returns readdatavalid one cycle after each accepted read.
    always @(negedge clk) begin
        master_readdatavalid = pend;
        master_readdata      = pend ? rdata[nrd-1] : 32'd0;
        pend                 = 1'b0;
        if (master_read === 1'b1 && master_write === 1'b1) hold_err++;
        if (held && (master_read !== h_rd || master_write !== h_wr ||
                     master_address !== h_addr || master_writedata !== h_data)) hold_err++;
        held = 1'b0;
        if (rst_n === 1'b0 && (master_read === 1'b1 || master_write === 1'b1) && nrd < 64 && nwr < 64) begin
            if (stall && st < 2) begin
                master_waitrequest = 1'b1;
                st++;
                held   = 1'b1;
                h_rd   = master_read;
                h_wr   = master_write;
                h_addr = master_address;
                h_data = master_writedata;
            end else begin
                master_waitrequest = 1'b0;
                st = 0;
                if (master_read) begin
                    rd_addr[nrd] = master_address;
                    nrd++;
                    pend = 1'b1;
                end else begin
                    wr_addr[nwr] = master_address;
                    wr_data[nwr] = master_writedata;
                    nwr++;
                end
            end
        end else begin
            master_waitrequest = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sw(input logic [3:0] a, input logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        #1;
        slave_address = a;
        slave_writedata = d;
        slave_write = 1'b1;
        #1;
        while (slave_waitrequest === 1'b1 && waits < 200) begin
            @(negedge clk);
            #2;
            waits++;
        end
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic sr(input logic [3:0] a, output logic [31:0] d, output int waits);
        waits = 0;
        @(negedge clk);
        #1;
        slave_address = a;
        slave_read = 1'b1;
        #1;
        while (slave_waitrequest === 1'b1 && waits < 200) begin
            @(negedge clk);
            #2;
            waits++;
        end
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic check_copy(input string tag, input int rb, input int wb,
                              input logic [31:0] s, input logic [31:0] dd, input int n);
        logic [31:0] off;
        chk({tag, "_nrd"}, nrd - rb, n);
        chk({tag, "_nwr"}, nwr - wb, n);
        for (int k = 0; k < n; k++) begin
            off = k * 4;
            chk({tag, "_rd_addr"}, rd_addr[rb+k], s + off);
            chk({tag, "_wr_addr"}, wr_addr[wb+k], dd + off);
            chk({tag, "_wr_data"}, wr_data[wb+k], rdata[rb+k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int w, rb, wb, n;
        for (int i = 0; i < 64; i++) rdata[i] = $urandom;
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_swait", {31'd0, slave_waitrequest}, 32'd0);
        chk("rst_srdata", slave_readdata, 32'd0);
        chk("rst_mread", {31'd0, master_read}, 32'd0);
        chk("rst_mwrite", {31'd0, master_write}, 32'd0);
        chk("rst_maddr", master_address, 32'd0);
        chk("rst_mwdata", master_writedata, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        for (int a = 1; a < 4; a++) begin
            sr(a[3:0], d, w);
            chk("rst_reg", d, 32'd0);
        end
        // register access
        sw(4'd1, 32'h1000_0000, w);
        sw(4'd2, 32'h2000_0000, w);
        sw(4'd3, 32'd4, w);
        sr(4'd1, d, w); chk("rd_dst", d, 32'h1000_0000);
        sr(4'd2, d, w); chk("rd_src", d, 32'h2000_0000);
        sr(4'd3, d, w); chk("rd_cnt", d, 32'd4);
        sr(4'd0, d, w); chk("rd_stat", d, 32'd0);
        sw(4'd9, 32'hDEAD_BEEF, w);
        sr(4'd9, d, w); chk("rd_hi_off", d, 32'd0);
        // 4-word copy, status read blocks for exactly 12 cycles
        rb = nrd; wb = nwr;
        sw(4'd0, 32'd0, w);
        sr(4'd0, d, w);
        chk("blk_waits", w, 32'd12);
        chk("blk_data", d, 32'd0);
        check_copy("copy", rb, wb, 32'h2000_0000, 32'h1000_0000, 4);
        chk("copy_idle_rd", {31'd0, master_read}, 32'd0);
        chk("copy_idle_wr", {31'd0, master_write}, 32'd0);
        // stalls of 2 cycles on every request, wrapping source, unaligned dest
        stall = 1'b1;
        sw(4'd1, 32'h3000_0002, w);
        sw(4'd2, 32'hFFFF_FFF8, w);
        rb = nrd; wb = nwr;
        sw(4'd0, 32'd0, w);
        sr(4'd0, d, w);
        chk("stall_waits", w, 32'd28);
        check_copy("stall", rb, wb, 32'hFFFF_FFF8, 32'h3000_0002, 4);
        chk("stall_rd1", rd_addr[rb+2], 32'h0000_0000);
        chk("stall_hold", hold_err, 32'd0);
        stall = 1'b0;
        // count = 0: no traffic, no stall
        sw(4'd3, 32'd0, w);
        rb = nrd; wb = nwr;
        sw(4'd0, 32'd0, w);
        chk("cnt0_start_waits", w, 32'd0);
        sr(4'd0, d, w);
        chk("cnt0_waits", w, 32'd0);
        repeat (3) @(posedge clk);
        chk("cnt0_nrd", nrd - rb, 32'd0);
        chk("cnt0_nwr", nwr - wb, 32'd0);
        // reset after the 2nd write of an 8-word copy
        sw(4'd1, 32'h4000_0000, w);
        sw(4'd2, 32'h5000_0000, w);
        sw(4'd3, 32'd8, w);
        rb = nrd; wb = nwr;
        sw(4'd0, 32'd0, w);
        n = 0;
        while (nwr - wb < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("mid_reached", {31'd0, n < 100}, 32'd1);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_mread", {31'd0, master_read}, 32'd0);
        chk("mid_mwrite", {31'd0, master_write}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_copy("mid", rb, wb, 32'h5000_0000, 32'h4000_0000, 2);
        chk("mid_swait", {31'd0, slave_waitrequest}, 32'd0);
        for (int a = 1; a < 4; a++) begin
            sr(a[3:0], d, w);
            chk("mid_reg", d, 32'd0);
        end
        chk("hold_total", hold_err, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
